// File: rtl/cacheline_adapter_pkg.sv
// Shared types and constants for the cacheline adapter: line/beat widths,
// the adapter state encoding and a beat-select helper.
package cacheline_adapter_pkg;

    localparam int LINE_W   = 256;
    localparam int BEAT_W   = 64;
    localparam int ADDR_W   = 32;
    localparam int BEATS    = LINE_W / BEAT_W;
    localparam int OFFSET_W = $clog2(LINE_W / 8);

    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [BEAT_W-1:0] beat_t;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        DONE,
        RELEASE
    } cla_state_t;

    // Beat 0 occupies the least significant bits of the line.
    function automatic beat_t get_beat(input line_t line, input logic [1:0] idx);
        return line[int'(idx)*BEAT_W +: BEAT_W];
    endfunction

endpackage

// File: rtl/cacheline_adapter.sv
// Splits 256-bit arbiter line requests into 4-beat 64-bit memory bursts and
// reassembles read bursts; one transaction in flight, one-cycle completion pulse.
//
// Memory handshake: address_o plus read_o/write_o form a request held for the
// whole burst; each cycle resp_i=1 transfers exactly one beat (burst_i sampled,
// or burst_o consumed), cycles with resp_i=0 transfer nothing. The burst ends
// on the fourth transferred beat.
module cacheline_adapter
    import cacheline_adapter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [ADDR_W-1:0] pmem_address,
    input  line_t             pmem_wdata,
    output line_t             pmem_rdata,
    output logic              pmem_resp,
    input  beat_t             burst_i,
    output beat_t             burst_o,
    output logic [ADDR_W-1:0] address_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i,
    output cla_state_t        dbg_state,
    output logic [1:0]        dbg_count
);

    cla_state_t state;
    logic [1:0] count;
    line_t      line;

    assign dbg_state = state;
    assign dbg_count = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= 2'd0;
            line       <= '0;
            pmem_rdata <= '0;
            pmem_resp  <= 1'b0;
            read_o     <= 1'b0;
            write_o    <= 1'b0;
            address_o  <= '0;
            burst_o    <= '0;
        end else begin
            pmem_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (pmem_write) begin
                        address_o <= {pmem_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        count     <= 2'd0;
                        line      <= pmem_wdata;
                        burst_o   <= get_beat(pmem_wdata, 2'd0);
                        write_o   <= 1'b1;
                        state     <= WRITE;
                    end else if (pmem_read) begin
                        address_o <= {pmem_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        count     <= 2'd0;
                        read_o    <= 1'b1;
                        state     <= READ;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        line[int'(count)*BEAT_W +: BEAT_W] <= burst_i;
                        count <= count + 2'd1;
                        if (count == LAST_BEAT) begin
                            // Final beat bypasses the buffer so the line is visible with the pulse.
                            pmem_rdata <= {burst_i, line[LINE_W-BEAT_W-1:0]};
                            pmem_resp  <= 1'b1;
                            read_o     <= 1'b0;
                            state      <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        count <= count + 2'd1;
                        if (count == LAST_BEAT) begin
                            burst_o   <= '0;
                            pmem_resp <= 1'b1;
                            write_o   <= 1'b0;
                            state     <= DONE;
                        end else begin
                            burst_o <= get_beat(line, count + 2'd1);
                        end
                    end
                end
                DONE: begin
                    state <= RELEASE;
                end
                RELEASE: begin
                    // A request still held from before the pulse must not start a new burst.
                    if (!pmem_read && !pmem_write) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Scoreboard bench for cacheline_adapter: directed line reads/writes with
// hand-written beats; a negedge monitor checks completions and write beats.
module tb_cacheline_adapter;
    import cacheline_adapter_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    line_t             pmem_wdata;
    line_t             pmem_rdata;
    logic              pmem_resp;
    beat_t             burst_i;
    beat_t             burst_o;
    logic [ADDR_W-1:0] address_o;
    logic              read_o;
    logic              write_o;
    logic              resp_i;
    cla_state_t        dbg_state;
    logic [1:0]        dbg_count;

    cacheline_adapter dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .burst_i      (burst_i),
        .burst_o      (burst_o),
        .address_o    (address_o),
        .read_o       (read_o),
        .write_o      (write_o),
        .resp_i       (resp_i),
        .dbg_state    (dbg_state),
        .dbg_count    (dbg_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int             checks = 0;
    int             errors = 0;
    int             rd_cycles = 0;
    line_t          last_rdata = '0;
    logic [LINE_W-1:0] exp_q[$];
    logic           exp_kind_q[$];
    logic [BEAT_W-1:0] exp_beat_q[$];

    task automatic chk(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (read_o) rd_cycles++;
            if (write_o && resp_i) begin
                if (exp_beat_q.size() == 0) chk("unexpected_write_beat", 1, 0);
                else chk("burst_o", burst_o, exp_beat_q.pop_front());
            end
            if (pmem_resp) begin
                chk("busy_at_resp", {read_o, write_o}, 0);
                if (exp_kind_q.size() == 0) begin
                    chk("unexpected_resp", 1, 0);
                end else if (exp_kind_q.pop_front() == 1'b0) begin
                    chk("pmem_rdata", pmem_rdata, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_addr,
                           input line_t data, input int gap);
        exp_kind_q.push_back(1'b0);
        exp_q.push_back(data);
        pmem_read    = 1'b1;
        pmem_address = addr;
        step();
        chk("read_o_start", read_o, 1);
        chk("read_address_o", address_o, exp_addr);
        pmem_address = 32'hFFFF_FFFF;
        for (int i = 0; i < BEATS; i++) begin
            repeat (gap) begin
                resp_i = 1'b0;
                burst_i = {$urandom, $urandom};
                step();
            end
            resp_i  = 1'b1;
            burst_i = data[i*BEAT_W +: BEAT_W];
            step();
        end
        resp_i  = 1'b0;
        burst_i = '0;
        chk("read_resp_pulse", pmem_resp, 1);
        chk("read_o_end", read_o, 0);
        last_rdata = data;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] exp_addr,
                            input line_t data, input int gap, input logic also_read);
        exp_kind_q.push_back(1'b1);
        for (int i = 0; i < BEATS; i++) exp_beat_q.push_back(data[i*BEAT_W +: BEAT_W]);
        pmem_write   = 1'b1;
        pmem_read    = also_read;
        pmem_address = addr;
        pmem_wdata   = data;
        step();
        chk("write_o_start", write_o, 1);
        chk("read_o_during_write", read_o, 0);
        chk("write_address_o", address_o, exp_addr);
        pmem_wdata = ~data;
        for (int i = 0; i < BEATS; i++) begin
            repeat (gap) begin
                resp_i = 1'b0;
                step();
                chk("write_o_gap", write_o, 1);
            end
            resp_i = 1'b1;
            step();
        end
        resp_i = 1'b0;
        chk("write_o_end", write_o, 0);
        chk("write_resp_pulse", pmem_resp, 1);
    endtask

    task automatic release_req();
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        step();
        step();
        chk("idle_after_release", dbg_state, IDLE);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        pmem_read = 1'b0;
        pmem_write = 1'b0;
        pmem_address = '0;
        pmem_wdata = '0;
        burst_i = '0;
        resp_i = 1'b0;
        step();
        step();
        chk("reset_resp", pmem_resp, 0);
        chk("reset_rdata", pmem_rdata, 0);
        chk("reset_rw", {read_o, write_o}, 0);
        chk("reset_addr", address_o, 0);
        chk("reset_burst_o", burst_o, 0);
        chk("reset_state", dbg_state, IDLE);
        chk("reset_count", dbg_count, 0);
        rst = 1'b0;
        step();

        // 1: back-to-back read, minimum latency, read_o exactly 4 cycles
        rd_cycles = 0;
        do_read(32'h0000_1234, 32'h0000_1220,
                {64'hA3A3_A3A3_3333_0003, 64'hA2A2_A2A2_2222_0002,
                 64'hA1A1_A1A1_1111_0001, 64'hA0A0_A0A0_0000_0000}, 0);
        release_req();
        chk("read_o_cycles", rd_cycles, 4);
        chk("rdata_held", pmem_rdata,
            {64'hA3A3_A3A3_3333_0003, 64'hA2A2_A2A2_2222_0002,
             64'hA1A1_A1A1_1111_0001, 64'hA0A0_A0A0_0000_0000});

        // 2: write with 2-cycle gaps, data changed after accept
        do_write(32'h8000_00FF, 32'h8000_00E0,
                 {64'hD3D3_0000_0000_0033, 64'hD2D2_0000_0000_0022,
                  64'hD1D1_0000_0000_0011, 64'hD0D0_0000_0000_0000}, 2, 1'b0);
        release_req();
        chk("rdata_kept_after_write", pmem_rdata, last_rdata);

        // 3: read and write both high -> write wins
        rd_cycles = 0;
        do_write(32'h0000_005F, 32'h0000_0040,
                 {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 1'b1);
        release_req();
        chk("no_read_on_collision", rd_cycles, 0);

        // 4: held request after completion is not re-accepted
        do_read(32'h0000_2000, 32'h0000_2000,
                {64'h0BAD_0000_0000_0004, 64'h0BAD_0000_0000_0003,
                 64'h0BAD_0000_0000_0002, 64'h0BAD_0000_0000_0001}, 0);
        step();
        step();
        step();
        chk("held_no_burst", read_o, 0);
        chk("held_release", dbg_state, RELEASE);
        pmem_read = 1'b0;
        step();
        chk("dropped_idle", dbg_state, IDLE);
        do_read(32'h0000_2040, 32'h0000_2040,
                {64'hCAFE_0000_0000_0004, 64'hCAFE_0000_0000_0003,
                 64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001}, 1);
        release_req();

        // 5: reset after two beats of a read
        pmem_read = 1'b1;
        pmem_address = 32'h0000_3000;
        step();
        resp_i = 1'b1;
        burst_i = 64'h5555_0000_0000_0000;
        step();
        burst_i = 64'h5555_0000_0000_0001;
        step();
        resp_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_read_o", read_o, 0);
        chk("rst_resp", pmem_resp, 0);
        chk("rst_count", dbg_count, 0);
        chk("rst_rdata", pmem_rdata, 0);
        last_rdata = '0;
        pmem_read = 1'b0;
        step();
        rst = 1'b0;
        step();
        do_read(32'h0000_3010, 32'h0000_3000,
                {64'h7777_0000_0000_0003, 64'h6666_0000_0000_0002,
                 64'h5555_0000_0000_0001, 64'h4444_0000_0000_0000}, 0);
        release_req();

        // 6: stray resp_i in IDLE and RELEASE
        resp_i = 1'b1;
        burst_i = {$urandom, $urandom};
        step();
        burst_i = {$urandom, $urandom};
        step();
        resp_i = 1'b0;
        chk("stray_idle_state", dbg_state, IDLE);
        chk("stray_idle_count", dbg_count, 0);
        chk("stray_idle_rdata", pmem_rdata, last_rdata);
        chk("stray_idle_rw", {read_o, write_o}, 0);
        do_read(32'h0000_4000, 32'h0000_4000,
                {64'h9999_0000_0000_0003, 64'h8888_0000_0000_0002,
                 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321}, 0);
        step();
        repeat (2) begin
            resp_i = 1'b1;
            burst_i = {$urandom_range(32'hFFFF_FFFF, 0), $urandom_range(32'hFFFF_FFFF, 0)};
            step();
        end
        resp_i = 1'b0;
        chk("stray_release_state", dbg_state, RELEASE);
        chk("stray_release_count", dbg_count, 0);
        chk("stray_release_rdata", pmem_rdata, last_rdata);
        release_req();

        step();
        chk("pending_resp", exp_kind_q.size(), 0);
        chk("pending_lines", exp_q.size(), 0);
        chk("pending_beats", exp_beat_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
